// File: rtl/rank_trim_pkg.sv
// Shared definitions for the rank-trimmed mean stage.
// Contents: FSM state encoding (one-hot), accumulator width helper and the
// rounding offset used to turn truncating division into round-half-up.
package rank_trim_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'b001,
        StAccum = 3'b010,
        StDiv   = 3'b100
    } state_e;

    // Wide enough for DN samples of DW bits plus the rounding offset.
    function automatic int unsigned sum_width(input int unsigned dw, input int unsigned dn);
        return dw + $clog2(dn) + 1;
    endfunction

    // Adding keep/2 before dividing by keep rounds half up.
    function automatic int unsigned round_offset(input int unsigned keep);
        return keep >> 1;
    endfunction

endpackage

// File: rtl/rank_trim_mean_if.sv
// Sorter-to-trimmed-mean bus.
// master (sorter side): drives sort_finish, data_unsort, idx_sorted; sees results.
// slave  (rank_trim_mean): consumes the window, drives busy, mean_out,
//                          mean_valid and idx_err.
interface rank_trim_mean_if #(
    parameter int unsigned DN   = 25,
    parameter int unsigned DW   = 8,
    parameter int unsigned DSEQ = $clog2(DN)
);
    logic                 sort_finish;
    logic [DW*DN-1:0]     data_unsort;
    logic [DSEQ*DN-1:0]   idx_sorted;
    logic                 busy;
    logic [DW-1:0]        mean_out;
    logic                 mean_valid;
    logic                 idx_err;

    modport master (
        output sort_finish, data_unsort, idx_sorted,
        input  busy, mean_out, mean_valid, idx_err
    );

    modport slave (
        input  sort_finish, data_unsort, idx_sorted,
        output busy, mean_out, mean_valid, idx_err
    );
endinterface

// File: rtl/seq_divider.sv
// Serial restoring divider by a constant.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   start       load dividend and begin; SW steps follow, one quotient bit each
//   dividend    SW-bit dividend, sampled when start=1
//   done        high in the cycle that performs the final step
//   quotient    quotient value as it will be after the current step; complete
//               when done=1
module seq_divider #(
    parameter int unsigned SW      = 14,
    parameter int unsigned DIVISOR = 17
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [SW-1:0] dividend,
    output logic          done,
    output logic [SW-1:0] quotient
);
    localparam int unsigned CW = $clog2(SW + 1);

    logic [SW-1:0] rem_q, quo_q;
    logic [CW-1:0] cnt_q;
    logic [SW:0]   shifted;
    logic          ge;
    logic [SW-1:0] rem_next, quo_next;

    // Remainder stays below DIVISOR, so the shifted trial fits in SW+1 bits.
    always_comb begin
        shifted  = {rem_q, quo_q[SW-1]};
        ge       = (shifted >= (SW+1)'(DIVISOR));
        rem_next = ge ? SW'(shifted - (SW+1)'(DIVISOR)) : shifted[SW-1:0];
        quo_next = {quo_q[SW-2:0], ge};
    end

    assign quotient = quo_next;
    assign done     = !start && (cnt_q == CW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q <= '0;
            quo_q <= '0;
            cnt_q <= '0;
        end else if (start) begin
            rem_q <= '0;
            quo_q <= dividend;
            cnt_q <= CW'(SW);
        end else if (cnt_q != '0) begin
            rem_q <= rem_next;
            quo_q <= quo_next;
            cnt_q <= cnt_q - CW'(1);
        end
    end
endmodule

// File: rtl/rank_trim_mean.sv
// Alpha-trimmed mean back end: drops TRIM ranks at each end of a sorted window,
// accumulates the KEEP middle samples serially and divides by KEEP with
// round-half-up, producing one pixel per window.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         rank_trim_mean_if.slave: sort_finish/data_unsort/idx_sorted in,
//               busy/mean_out/mean_valid/idx_err out (all registered)
module rank_trim_mean
    import rank_trim_pkg::*;
#(
    parameter int unsigned DN   = 25,
    parameter int unsigned DW   = 8,
    parameter int unsigned DSEQ = $clog2(DN),
    parameter int unsigned TRIM = 4
) (
    input logic             clk,
    input logic             rst_n,
    rank_trim_mean_if.slave bus
);
    localparam int unsigned KEEP   = DN - 2 * TRIM;
    localparam int unsigned SW     = sum_width(DW, DN);
    localparam int unsigned OFFSET = round_offset(KEEP);
    localparam int unsigned LAST   = DN - 1 - TRIM;

    if (2 * TRIM >= DN) begin : g_bad_trim
        $error("rank_trim_mean: 2*TRIM must be less than DN");
    end

    state_e               state_q;
    logic [DW*DN-1:0]     data_q;
    logic [DSEQ*DN-1:0]   idx_q;
    logic [DSEQ-1:0]      ptr_q;
    logic [SW-1:0]        acc_q;
    logic                 div_start_q;
    logic                 busy_q;
    logic [DW-1:0]        mean_out_q;
    logic                 mean_valid_q;
    logic                 idx_err_q;

    logic [DSEQ-1:0]      cur_idx;
    logic [DW-1:0]        sample;
    logic                 idx_bad;
    logic [SW-1:0]        addend;
    logic                 div_done;
    logic [SW-1:0]        div_quot;

    // Rank pointer -> sample index -> sample. An out-of-range index matches
    // no sample and so contributes 0.
    always_comb begin
        cur_idx = '0;
        for (int r = 0; r < DN; r++) begin
            if (ptr_q == DSEQ'(r)) cur_idx = idx_q[r*DSEQ +: DSEQ];
        end
        sample = '0;
        for (int i = 0; i < DN; i++) begin
            if (cur_idx == DSEQ'(i)) sample = data_q[i*DW +: DW];
        end
        idx_bad = (32'(cur_idx) >= DN);
        addend  = idx_bad ? '0 : SW'(sample);
    end

    seq_divider #(
        .SW      (SW),
        .DIVISOR (KEEP)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start_q),
        .dividend (acc_q + SW'(OFFSET)),
        .done     (div_done),
        .quotient (div_quot)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            data_q       <= '0;
            idx_q        <= '0;
            ptr_q        <= '0;
            acc_q        <= '0;
            div_start_q  <= 1'b0;
            busy_q       <= 1'b0;
            mean_out_q   <= '0;
            mean_valid_q <= 1'b0;
            idx_err_q    <= 1'b0;
        end else begin
            mean_valid_q <= 1'b0;
            div_start_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.sort_finish) begin
                        data_q    <= bus.data_unsort;
                        idx_q     <= bus.idx_sorted;
                        acc_q     <= '0;
                        idx_err_q <= 1'b0;
                        ptr_q     <= DSEQ'(TRIM);
                        busy_q    <= 1'b1;
                        state_q   <= StAccum;
                    end
                end
                StAccum: begin
                    acc_q <= acc_q + addend;
                    if (idx_bad) idx_err_q <= 1'b1;
                    ptr_q <= ptr_q + DSEQ'(1);
                    if (ptr_q == DSEQ'(LAST)) begin
                        // Divider loads on the first DIV cycle, once acc_q is final.
                        div_start_q <= 1'b1;
                        state_q     <= StDiv;
                    end
                end
                StDiv: begin
                    if (div_done) begin
                        mean_out_q   <= DW'(div_quot);
                        mean_valid_q <= 1'b1;
                        busy_q       <= 1'b0;
                        state_q      <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.mean_out   = mean_out_q;
    assign bus.mean_valid = mean_valid_q;
    assign bus.idx_err    = idx_err_q;
endmodule

// File: tb/tb_rank_trim_mean.sv
// Self-checking bench for rank_trim_mean: directed cases plus random windows
// checked against a rank-based reference model.
module tb_rank_trim_mean;
    localparam int unsigned DN   = 25;
    localparam int unsigned DW   = 8;
    localparam int unsigned DSEQ = $clog2(DN);
    localparam int unsigned TRIM = 4;
    localparam int unsigned KEEP = DN - 2 * TRIM;
    localparam int          LAT  = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rank_trim_mean_if #(.DN(DN), .DW(DW), .DSEQ(DSEQ)) bus ();

    rank_trim_mean #(.DN(DN), .DW(DW), .DSEQ(DSEQ), .TRIM(TRIM)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int compared = 0;
    int mismatched = 0;
    int dat[DN];
    int idx[DN];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Mean of the ranks that survive trimming, bad indices counting as 0.
    function automatic int ref_mean();
        int sum = 0;
        for (int r = TRIM; r < DN - TRIM; r++) if (idx[r] < DN) sum += dat[idx[r]];
        return (sum + KEEP / 2) / KEEP;
    endfunction

    function automatic int ref_err();
        for (int r = TRIM; r < DN - TRIM; r++) if (idx[r] >= DN) return 1;
        return 0;
    endfunction

    task automatic fill(input int v);
        for (int i = 0; i < DN; i++) begin
            dat[i] = v;
            idx[i] = i;
        end
    endtask

    // Rank order by value (stable), as a real sorter would produce.
    task automatic sort_idx();
        for (int i = 0; i < DN; i++) idx[i] = i;
        for (int i = 1; i < DN; i++) begin
            for (int j = i; j > 0 && dat[idx[j-1]] > dat[idx[j]]; j--) begin
                int t = idx[j];
                idx[j] = idx[j-1];
                idx[j-1] = t;
            end
        end
    endtask

    task automatic drive_bus();
        for (int i = 0; i < DN; i++) begin
            bus.data_unsort[i*DW +: DW] = DW'(dat[i]);
            bus.idx_sorted[i*DSEQ +: DSEQ] = DSEQ'(idx[i]);
        end
    endtask

    // Returns #1 after the accepting edge E0.
    task automatic start_window();
        @(negedge clk);
        drive_bus();
        bus.sort_finish = 1'b1;
        @(posedge clk);
        #1 bus.sort_finish = 1'b0;
    endtask

    task automatic wait_result(output int lat, output int busy_cnt);
        lat = 0;
        busy_cnt = bus.busy ? 1 : 0;
        while (!bus.mean_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.busy) busy_cnt++;
        end
    endtask

    task automatic run_check(input string tag);
        int lat, bc;
        start_window();
        wait_result(lat, bc);
        check({tag, "_latency"}, lat, LAT);
        check({tag, "_mean"}, bus.mean_out, ref_mean());
        check({tag, "_err"}, bus.idx_err, ref_err());
    endtask

    initial begin
        int lat, bc, pulses;
        logic [DW-1:0] seen;
        bus.sort_finish = 1'b0;
        bus.data_unsort = '0;
        bus.idx_sorted = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", bus.busy, 0);
        check("rst_valid", bus.mean_valid, 0);
        check("rst_mean", bus.mean_out, 0);
        check("rst_err", bus.idx_err, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Flat window: latency, busy duration, single-cycle pulse
        fill(100);
        start_window();
        wait_result(lat, bc);
        check("flat_latency", lat, LAT);
        check("flat_busy_cycles", bc, LAT);
        check("flat_mean", bus.mean_out, 100);
        check("flat_err", bus.idx_err, 0);
        @(posedge clk);
        #1;
        check("flat_pulse_width", bus.mean_valid, 0);
        check("flat_mean_hold", bus.mean_out, 100);

        // Ramp i*10
        for (int i = 0; i < DN; i++) dat[i] = i * 10;
        run_check("ramp");
        check("ramp_value", bus.mean_out, 120);

        // Outlier rejection
        fill(50);
        for (int i = 0; i < 4; i++) dat[i] = 0;
        for (int i = 21; i < DN; i++) dat[i] = 255;
        run_check("outlier");
        check("outlier_value", bus.mean_out, 50);

        // Rounding boundaries
        fill(10); dat[4] = 18;
        run_check("round_down");
        check("round_down_value", bus.mean_out, 10);
        fill(10); dat[4] = 19;
        run_check("round_up");
        check("round_up_value", bus.mean_out, 11);
        fill(255);
        run_check("max");
        check("max_value", bus.mean_out, 255);

        // Out-of-range index at a kept rank
        for (int i = 0; i < DN; i++) begin dat[i] = i * 10; idx[i] = i; end
        idx[10] = 31;
        run_check("bad_idx");
        check("bad_idx_flag", bus.idx_err, 1);

        // Second start mid-ACCUM is ignored
        fill(40);
        start_window();
        repeat (4) @(negedge clk);
        fill(200);
        drive_bus();
        bus.sort_finish = 1'b1;
        @(negedge clk);
        bus.sort_finish = 1'b0;
        pulses = 0;
        seen = '0;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk);
            #1;
            if (bus.mean_valid) begin
                pulses++;
                seen = bus.mean_out;
            end
        end
        check("ignore_pulses", pulses, 1);
        check("ignore_mean", seen, 40);

        // Back-to-back: next start accepted in the mean_valid cycle
        fill(60);
        start_window();
        wait_result(lat, bc);
        check("b2b_first", bus.mean_out, 60);
        fill(90);
        start_window();
        wait_result(lat, bc);
        check("b2b_latency", lat, LAT);
        check("b2b_mean", bus.mean_out, 90);

        // Reset during DIV
        fill(77);
        start_window();
        repeat (22) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_valid", bus.mean_valid, 0);
        check("mid_rst_mean", bus.mean_out, 0);
        check("mid_rst_err", bus.idx_err, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (bus.mean_valid) pulses++;
        end
        check("mid_rst_no_pulse", pulses, 0);
        fill(33); dat[7] = 200;
        run_check("post_rst");

        // Random sorted windows, some with a corrupted kept rank
        for (int n = 0; n < 20; n++) begin
            for (int i = 0; i < DN; i++) dat[i] = $urandom_range(0, 255);
            sort_idx();
            if ($urandom_range(0, 3) == 0) idx[$urandom_range(TRIM, DN - 1 - TRIM)] = $urandom_range(DN, 31);
            run_check("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/rank_trim_mean.md
Name: rank_trim_mean

Overview:
- Consumer at the output end of the parallel sorting stage in the modified alpha-trimmed mean filter.
- Takes the DN-sample window and the sorted-index vector (index of the sample at each rank position), discards TRIM samples at each end, sums the remaining KEEP = DN-2*TRIM samples serially, divides by KEEP, and emits one filtered pixel per window.
- Sits between the sorter and the pixel output stage; it is started by the sorter's sort_finish pulse.

Parameters:
- DN, 25, samples per window.
- DW, 8, sample width.
- DSEQ, $clog2(DN), sorted-index field width.
- TRIM, 4, samples discarded at each end. Elaboration check: 2*TRIM < DN.
- KEEP (localparam), DN-2*TRIM, samples averaged (17 at defaults).
- SW (localparam), DW+$clog2(DN)+1, accumulator and divider width (14 at defaults).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- sort_finish  in  1  start pulse from the sorter; the bus inputs are valid in the same cycle.
- data_unsort  in  DW*DN  window samples; sample i is at [i*DW +: DW].
- idx_sorted  in  DSEQ*DN  rank position r holds the sample index at [r*DSEQ +: DSEQ]; rank 0 is the smallest.
- busy  out  1  high while a window is in flight.
- mean_out  out  DW  trimmed mean, rounded to nearest.
- mean_valid  out  1  one-cycle pulse; mean_out is valid in that cycle.
- idx_err  out  1  sticky per window; set if any kept rank carries an index >= DN.

Behaviour:
- Reset values: all outputs 0; state IDLE; internal latches and accumulator 0.
- States are one-hot: IDLE = 3'b001, ACCUM = 3'b010, DIV = 3'b100.
- IDLE:
  - When sort_finish=1, latch data_unsort and idx_sorted.
  - Clear the accumulator and idx_err.
  - Load the rank pointer with TRIM, set busy=1, and go to ACCUM.
- ACCUM:
  - Runs for KEEP cycles, with the pointer walking TRIM..DN-1-TRIM.
  - Each cycle adds data[idx_sorted[ptr]] to the SW-bit accumulator.
  - If the index is >= DN, add 0 instead and set idx_err.
  - After the last add, go to DIV.
- DIV:
  - Load the dividend as acc + (KEEP>>1) to round half up. This cannot overflow SW bits.
  - Run a restoring division by the constant KEEP, one quotient bit per cycle, for SW cycles.
  - On the final cycle, register mean_out = quotient[DW-1:0]. The quotient always fits in DW bits.
  - Pulse mean_valid, clear busy, and return to IDLE.
- Latency: with the start sampled at edge E0, mean_valid is high after edge E0+KEEP+SW+1. At defaults that is edge E0+32.
- Throughput: a new sort_finish is accepted in the cycle mean_valid is high, since busy is already 0.
- sort_finish while busy=1: ignored. No queueing and no error flag.
- mean_out holds its value until the next mean_valid. idx_err holds until the next accepted start.
- The block does not check that idx_sorted is a permutation or monotonic. Duplicate indices are summed as given.
- Reset mid-operation: state goes to IDLE at once, and busy, mean_valid and idx_err go to 0. The in-flight result is discarded and no mean_valid is emitted.
- Input buses are sampled only on the accepting cycle. Changes to them while busy have no effect.

Decomposition:
- Package rank_trim_pkg holds:
  - the state encodings IDLE/ACCUM/DIV;
  - a width helper for SW;
  - a constant function for the KEEP rounding offset.
- Sub-module seq_divider, a serial restoring divider:
  - Parameters: width SW and a constant divisor.
  - Ports: start, done, dividend, quotient.
  - The top level owns the FSM, the rank pointer, the sample mux and the accumulator.

Test Plan:
- All 25 samples = 100, idx identity, one start -> mean_valid at edge E0+32 with mean_out=100, idx_err=0, busy high for exactly 32 cycles.
- Samples i*10 (0..240), idx identity -> kept ranks 4..20 sum 2040 -> mean_out=120.
- Outlier rejection: samples 0..3 = 0, samples 21..24 = 255, rest = 50, idx identity -> mean_out=50.
- Rounding, all samples 10, idx identity:
  - sample 4 = 18 -> sum 178 -> mean_out=10;
  - sample 4 = 19 -> sum 179 -> mean_out=11;
  - all 255 -> mean_out=255, no overflow.
- Error and protocol:
  - idx_sorted[10]=31 -> idx_err=1 and that term counts as 0;
  - a second sort_finish mid-ACCUM is ignored, giving exactly one mean_valid;
  - back-to-back start in the mean_valid cycle is accepted.
- rst_n low during DIV -> busy=0, mean_valid=0, mean_out=0 immediately; no pulse after release; the next window computes correctly.
